// File: rtl/enet_gmii_tx_framer_if.sv
// -----------------------------------------------------------------------------
// enet_gmii_tx_framer_if
// Payload byte stream between the TX FIFO / DMA and the GMII framer.
//   tx_data  : payload byte
//   tx_valid : tx_data is valid
//   tx_last  : current byte is the last of the frame
//   tx_ready : byte accepted when tx_valid && tx_ready
// master = byte source, slave = framer.
// -----------------------------------------------------------------------------
interface enet_gmii_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/enet_gmii_tx_framer.sv
// -----------------------------------------------------------------------------
// enet_gmii_tx_framer
// MAC-side GMII transmit framer: preamble, SFD, payload, optional zero pad,
// CRC-32 FCS (LSB first) and inter-frame gap.
//
// Ports
//   gmii_tx_clk : the only clock (GMII transmit clock)
//   rst         : synchronous, active-high reset
//   tx          : payload byte stream (slave side of enet_gmii_tx_framer_if)
//   gmii_tx_en  : GMII transmit enable (registered)
//   gmii_tx_er  : GMII transmit error (registered)
//   gmii_txd    : GMII transmit data (registered)
//   frame_done  : pulse while the last FCS byte is on gmii_txd
//   frame_err   : pulse while gmii_tx_er is high
//
// Parameters
//   IFG_CYCLES  : idle cycles after the last FCS byte (1..255); one extra
//                 cycle is spent in IDLE before the next preamble
//   MIN_PAYLOAD : minimum bytes between SFD and FCS when padding is built in
//
// Build option
//   ENET_TX_PAD_EN : when defined, runt frames are zero-padded to MIN_PAYLOAD
//                    bytes and the pad is covered by the CRC.
//
// The state names the producer of the next wire byte: the output flops are
// loaded from the current state, so a state's byte appears one cycle later.
// -----------------------------------------------------------------------------
module enet_gmii_tx_framer #(
    parameter int IFG_CYCLES  = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic                 gmii_tx_clk,
    input  logic                 rst,
    enet_gmii_tx_framer_if.slave tx,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic [7:0]           gmii_txd,
    output logic                 frame_done,
    output logic                 frame_err
);
    typedef enum logic [3:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, ABORT, DROP, IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    // IFG counts down to zero inclusive, giving IFG_CYCLES+1 low cycles on the
    // wire before IDLE can launch the next preamble byte.
    localparam logic [7:0]  IFG_LOAD      = 8'(IFG_CYCLES);
`ifdef ENET_TX_PAD_EN
    localparam logic [15:0] PAD_LAST      = 16'(MIN_PAYLOAD - 1);
`endif

    if (IFG_CYCLES < 1 || IFG_CYCLES > 255 || MIN_PAYLOAD < 1 || MIN_PAYLOAD > 65535) begin : g_param_check
        $error("enet_gmii_tx_framer: IFG_CYCLES or MIN_PAYLOAD out of range");
    end

    // Reflected CRC-32, one byte per call.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_reg, state_next;
    logic [2:0]  pre_cnt_reg, pre_cnt_next;
    logic [1:0]  fcs_idx_reg, fcs_idx_next;
    logic [7:0]  ifg_cnt_reg, ifg_cnt_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
    logic [31:0] crc_reg, crc_next;
    logic [7:0]  txd_reg, txd_next;
    logic        tx_en_reg, tx_en_next;
    logic        tx_er_reg, tx_er_next;
    logic        frame_done_reg, frame_done_next;
    logic        frame_err_reg, frame_err_next;
    logic [7:0]  fcs_byte [4];

    // Complemented CRC split into wire bytes, least-significant byte first.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fcs_byte
        assign fcs_byte[gi] = ~crc_reg[8*gi +: 8];
    end

    assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            pre_cnt_reg    <= '0;
            fcs_idx_reg    <= '0;
            ifg_cnt_reg    <= '0;
            byte_cnt_reg   <= '0;
            crc_reg        <= '1;
            txd_reg        <= '0;
            tx_en_reg      <= 1'b0;
            tx_er_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pre_cnt_reg    <= pre_cnt_next;
            fcs_idx_reg    <= fcs_idx_next;
            ifg_cnt_reg    <= ifg_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            crc_reg        <= crc_next;
            txd_reg        <= txd_next;
            tx_en_reg      <= tx_en_next;
            tx_er_reg      <= tx_er_next;
            frame_done_reg <= frame_done_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pre_cnt_next    = pre_cnt_reg;
        fcs_idx_next    = fcs_idx_reg;
        ifg_cnt_next    = ifg_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        crc_next        = crc_reg;
        txd_next        = 8'h00;
        tx_en_next      = 1'b0;
        tx_er_next      = 1'b0;
        frame_done_next = 1'b0;
        frame_err_next  = 1'b0;
        tx.tx_ready     = 1'b0;

        case (state_reg)
            IDLE: begin
                // The first preamble byte is launched from here; the payload
                // byte stays on the bus until DATA.
                if (tx.tx_valid) begin
                    state_next   = PRE;
                    pre_cnt_next = '0;
                    tx_en_next   = 1'b1;
                    txd_next     = PREAMBLE_BYTE;
                end
            end
            PRE: begin
                // Six more preamble bytes after the one launched from IDLE.
                tx_en_next   = 1'b1;
                txd_next     = PREAMBLE_BYTE;
                pre_cnt_next = pre_cnt_reg + 3'd1;
                if (pre_cnt_reg == 3'd5) begin
                    state_next = SFD;
                end
            end
            SFD: begin
                tx_en_next    = 1'b1;
                txd_next      = SFD_BYTE;
                crc_next      = '1;
                byte_cnt_next = '0;
                state_next    = DATA;
            end
            DATA: begin
                tx.tx_ready = 1'b1;
                if (tx.tx_valid) begin
                    tx_en_next    = 1'b1;
                    txd_next      = tx.tx_data;
                    crc_next      = crc32_byte(crc_reg, tx.tx_data);
                    byte_cnt_next = byte_cnt_inc;
                    if (tx.tx_last) begin
                        fcs_idx_next = '0;
`ifdef ENET_TX_PAD_EN
                        state_next = (byte_cnt_reg < PAD_LAST) ? PAD : FCS;
`else
                        state_next = FCS;
`endif
                    end
                end else begin
                    // Underrun: poison the frame on the wire.
                    tx_en_next     = 1'b1;
                    tx_er_next     = 1'b1;
                    frame_err_next = 1'b1;
                    state_next     = ABORT;
                end
            end
`ifdef ENET_TX_PAD_EN
            PAD: begin
                tx_en_next    = 1'b1;
                crc_next      = crc32_byte(crc_reg, 8'h00);
                byte_cnt_next = byte_cnt_inc;
                if (byte_cnt_reg >= PAD_LAST) begin
                    fcs_idx_next = '0;
                    state_next   = FCS;
                end
            end
`endif
            FCS: begin
                tx_en_next   = 1'b1;
                txd_next     = fcs_byte[fcs_idx_reg];
                fcs_idx_next = fcs_idx_reg + 2'd1;
                if (fcs_idx_reg == 2'd3) begin
                    frame_done_next = 1'b1;
                    ifg_cnt_next    = IFG_LOAD;
                    state_next      = IFG;
                end
            end
            ABORT: begin
                // A tx_last byte can only arrive after the underrun, so the
                // remainder of the frame is always absorbed in DROP.
                state_next = DROP;
            end
            DROP: begin
                tx.tx_ready = 1'b1;
                if (tx.tx_valid && tx.tx_last) begin
                    ifg_cnt_next = IFG_LOAD;
                    state_next   = IFG;
                end
            end
            IFG: begin
                if (ifg_cnt_reg == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign gmii_tx_en = tx_en_reg;
    assign gmii_tx_er = tx_er_reg;
    assign gmii_txd   = txd_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
endmodule

// File: tb/tb_enet_gmii_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_enet_gmii_tx_framer
// Directed bench for enet_gmii_tx_framer. Every cycle's GMII outputs are
// logged (sampled 1 ns after the rising edge); each scenario then compares the
// log against hand-derived wire sequences.
// -----------------------------------------------------------------------------
module tb_enet_gmii_tx_framer;
    localparam int IFG_CYCLES  = 12;
    localparam int MIN_PAYLOAD = 60;
    localparam int LOG_MAX     = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic [7:0] gmii_txd;
    logic       frame_done;
    logic       frame_err;

    enet_gmii_tx_framer_if bif();

    enet_gmii_tx_framer #(
        .IFG_CYCLES (IFG_CYCLES),
        .MIN_PAYLOAD(MIN_PAYLOAD)
    ) dut (
        .gmii_tx_clk(clk),
        .rst        (rst),
        .tx         (bif),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .gmii_txd   (gmii_txd),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #4 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame_buf [128];
    logic       log_en   [LOG_MAX];
    logic       log_er   [LOG_MAX];
    logic [7:0] log_txd  [LOG_MAX];
    logic       log_done [LOG_MAX];
    logic       log_err  [LOG_MAX];
    logic       log_rdy  [LOG_MAX];
    int         log_n = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (log_n < LOG_MAX) begin
            log_en[log_n]   = gmii_tx_en;
            log_er[log_n]   = gmii_tx_er;
            log_txd[log_n]  = gmii_txd;
            log_done[log_n] = frame_done;
            log_err[log_n]  = frame_err;
            log_rdy[log_n]  = bif.tx_ready;
            log_n++;
        end
    endtask

    task automatic idle(input int n);
        bif.tx_valid = 1'b0;
        bif.tx_last  = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents frame_buf[0..len-1]; optionally drops tx_valid for one cycle
    // once gap_after bytes are accepted. Leaves the bus as-is on return.
    task automatic send_frame(input int len, input int gap_after, input int max_ticks, output int accepted);
        int   i;
        int   t;
        bit   gap_done;
        logic rdy;
        i = 0;
        t = 0;
        gap_done = 1'b0;
        while (i < len && t < max_ticks) begin
            if (gap_after > 0 && i == gap_after && !gap_done) begin
                bif.tx_valid = 1'b0;
                gap_done = 1'b1;
                tick();
            end else begin
                bif.tx_valid = 1'b1;
                bif.tx_data  = frame_buf[i];
                bif.tx_last  = (i == len - 1);
                rdy = bif.tx_ready;
                tick();
                if (rdy) i++;
            end
            t++;
        end
        accepted = i;
    endtask

    function automatic int find_en(input int from);
        for (int i = from; i < log_n; i++) if (log_en[i]) return i;
        return -1;
    endfunction

    function automatic int find_done(input int from);
        for (int i = from; i < log_n; i++) if (log_done[i]) return i;
        return -1;
    endfunction

    // which: 0 = tx_en, 1 = tx_er, 2 = frame_done, 3 = frame_err
    function automatic int cnt(input int which, input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < log_n) begin
                case (which)
                    0: if (log_en[i]) n++;
                    1: if (log_er[i]) n++;
                    2: if (log_done[i]) n++;
                    default: if (log_err[i]) n++;
                endcase
            end
        end
        return n;
    endfunction

    function automatic int wire_len(input int len);
`ifdef ENET_TX_PAD_EN
        return (len < MIN_PAYLOAD) ? MIN_PAYLOAD : len;
`else
        return len;
`endif
    endfunction

    // Reference FCS (already complemented) over the bytes between SFD and FCS.
    function automatic logic [31:0] ref_fcs(input int len);
        logic [31:0] c;
        logic [7:0]  d;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < wire_len(len); i++) begin
            d = (i < len) ? frame_buf[i] : 8'h00;
            c = c ^ {24'h0, d};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic load_ascii();
        for (int i = 0; i < 9; i++) frame_buf[i] = 8'h31 + 8'(i);
    endtask

    // Full wire image of a good frame starting at log index s.
    task automatic check_frame(input string tag, input int s, input int len);
        int          wl;
        int          bad;
        logic [31:0] fcs;
        logic [7:0]  exp_b;
        wl  = wire_len(len);
        fcs = ref_fcs(len);
        bad = 0;
        for (int k = 0; k < 7; k++) chk({tag, "_pre"}, {23'h0, log_en[s+k], log_txd[s+k]}, {23'h0, 1'b1, 8'h55});
        chk({tag, "_sfd"}, {23'h0, log_en[s+7], log_txd[s+7]}, {23'h0, 1'b1, 8'hD5});
        for (int k = 0; k < wl; k++) begin
            exp_b = (k < len) ? frame_buf[k] : 8'h00;
            if ({log_en[s+8+k], log_txd[s+8+k]} !== {1'b1, exp_b}) bad++;
        end
        chk({tag, "_payload_bad_bytes"}, bad, 0);
        for (int k = 0; k < 4; k++)
            chk({tag, "_fcs"}, {23'h0, log_en[s+8+wl+k], log_txd[s+8+wl+k]}, {23'h0, 1'b1, fcs[8*k +: 8]});
        chk({tag, "_done_on_last_fcs"}, {31'h0, log_done[s+wl+11]}, 32'd1);
        chk({tag, "_done_count"}, cnt(2, s, s + wl + 12), 1);
        chk({tag, "_en_after_fcs"}, {31'h0, log_en[s+wl+12]}, 32'd0);
        chk({tag, "_en_cycles"}, cnt(0, s, s + wl + 12), wl + 12);
        chk({tag, "_er_cycles"}, cnt(1, s, s + wl + 12), 0);
        $display("frame %s: start=%0d tx_en_cycles=%0d fcs=%08h", tag, s, cnt(0, s, s + wl + 12), fcs);
    endtask

    initial begin
        int          acc;
        int          s2;
        int          done1;
        logic [31:0] crc1;
        logic [7:0]  fcs_9 [4];

        fcs_9[0] = 8'h26; fcs_9[1] = 8'h39; fcs_9[2] = 8'hF4; fcs_9[3] = 8'hCB;
        rst          = 1'b1;
        bif.tx_data  = 8'h00;
        bif.tx_valid = 1'b0;
        bif.tx_last  = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        chk("reset_outputs", {26'h0, gmii_tx_en, gmii_tx_er, frame_done, frame_err, bif.tx_ready, 1'b0}, 32'h0);
        chk("reset_txd", {24'h0, gmii_txd}, 32'h0);
        rst = 1'b0;
        idle(3);
        chk("idle_en", {31'h0, gmii_tx_en}, 32'h0);
        $display("reset: outputs idle");

        // ---- "123456789" ----
        load_ascii();
        log_n = 0;
        send_frame(9, 0, 200, acc);
        idle(IFG_CYCLES + 6);
        chk("t1_accepted", acc, 9);
        chk("t1_first_en_latency", find_en(0), 0);
        chk("t1_ready_low_in_sfd", {31'h0, log_rdy[6]}, 32'd0);
        chk("t1_ready_high_cycle8", {31'h0, log_rdy[7]}, 32'd1);
        check_frame("t1_123456789", 0, 9);
`ifndef ENET_TX_PAD_EN
        for (int k = 0; k < 4; k++) chk("t1_fcs_const", {24'h0, log_txd[17+k]}, {24'h0, fcs_9[k]});
        chk("t1_done_idx", find_done(0), 20);
        chk("t1_en_total", cnt(0, 0, log_n - 1), 21);
`endif

        // ---- two 64-byte frames back to back ----
        for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i);
        crc1 = ref_fcs(64);
        log_n = 0;
        send_frame(64, 0, 300, acc);
        chk("t2_f1_accepted", acc, 64);
        for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i) ^ 8'hA5;
        send_frame(64, 0, 300, acc);
        chk("t2_f2_accepted", acc, 64);
        idle(IFG_CYCLES + 6);
        done1 = find_done(0);
        chk("t2_f1_done_idx", done1, 75);
        if (done1 < 3) done1 = 3;
        for (int k = 0; k < 4; k++) chk("t2_f1_fcs", {24'h0, log_txd[done1-3+k]}, {24'h0, crc1[8*k +: 8]});
        s2 = find_en(done1 + 1);
        chk("t2_gap_done_to_preamble", s2 - done1, IFG_CYCLES + 2);
        if (s2 < 0) s2 = 0;
        check_frame("t2_f2", s2, 64);

        // ---- underrun after byte 10 of a 20-byte frame ----
        for (int i = 0; i < 20; i++) frame_buf[i] = 8'h10 + 8'(i);
        log_n = 0;
        send_frame(20, 10, 300, acc);
        chk("t3_all_bytes_absorbed", acc, 20);
        load_ascii();
        send_frame(9, 0, 300, acc);
        chk("t3_next_accepted", acc, 9);
        idle(IFG_CYCLES + 6);
        for (int k = 0; k < 10; k++) chk("t3_payload", {23'h0, log_en[8+k], log_txd[8+k]}, {23'h0, 1'b1, 8'h10 + 8'(k)});
        chk("t3_abort_cycle", {22'h0, log_en[18], log_er[18], log_txd[18]}, {22'h0, 1'b1, 1'b1, 8'h00});
        chk("t3_frame_err_at_abort", {31'h0, log_err[18]}, 32'd1);
        s2 = find_en(19);
        chk("t3_next_found", {31'h0, (s2 > 19)}, 32'd1);
        if (s2 < 19) s2 = 19;
        chk("t3_en_low_in_drop", cnt(0, 19, s2 - 1), 0);
        chk("t3_ifg_respected", {31'h0, (s2 - 18 - 1 >= IFG_CYCLES)}, 32'd1);
        chk("t3_er_count", cnt(1, 0, log_n - 1), 1);
        chk("t3_err_count", cnt(3, 0, log_n - 1), 1);
        chk("t3_no_done_for_aborted", cnt(2, 0, s2 - 1), 0);
        $display("frame t3_underrun: abort_idx=18 next_start=%0d", s2);
        check_frame("t3_after_abort", s2, 9);

        // ---- reset during the 5th payload byte ----
        for (int i = 0; i < 20; i++) frame_buf[i] = 8'h30 + 8'(i);
        log_n = 0;
        send_frame(20, 0, 13, acc);
        chk("t4_accepted_before_rst", acc, 5);
        chk("t4_fifth_byte_on_wire", {23'h0, gmii_tx_en, gmii_txd}, {23'h0, 1'b1, 8'h34});
        rst = 1'b1;
        tick();
        chk("t4_en_after_rst", {30'h0, gmii_tx_en, gmii_tx_er}, 32'h0);
        chk("t4_txd_after_rst", {24'h0, gmii_txd}, 32'h0);
        rst = 1'b0;
        idle(1);
        chk("t4_ready_low_idle", {31'h0, bif.tx_ready}, 32'd0);
        idle(2);
        load_ascii();
        log_n = 0;
        send_frame(9, 0, 200, acc);
        idle(IFG_CYCLES + 6);
        chk("t4_next_accepted", acc, 9);
        chk("t4_next_start", find_en(0), 0);
        check_frame("t4_after_rst", 0, 9);

`ifdef ENET_TX_PAD_EN
        // ---- 1-byte runt padded to MIN_PAYLOAD ----
        frame_buf[0] = 8'h00;
        log_n = 0;
        send_frame(1, 0, 200, acc);
        idle(IFG_CYCLES + 6);
        chk("t5_accepted", acc, 1);
        chk("t5_en_total", cnt(0, 0, log_n - 1), 72);
        check_frame("t5_runt_pad", 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
